// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Purpose  : Shared definitions for the draw command receiver: command
//            opcodes, parser state encoding and the pixel color width.
// Revision : 1.0  initial release
// ============================================================================
package draw_pkg;

    // Command opcodes carried in header word bits [15:12]
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PIXEL = 4'h1;
    localparam logic [3:0] OP_HLINE = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;

    // Pixel color is {R,G,B}, one bit each
    localparam int COLOR_W = 3;

    // Command parser states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_X   = 3'd1,
        ST_GET_Y   = 3'd2,
        ST_GET_LEN = 3'd3,
        ST_EMIT    = 3'd4
    } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Synchronous single-clock FIFO buffering command words.
//            A push while full is dropped, even if a pop occurs in the same
//            cycle. Read data is the current head word (show-ahead), so a word
//            written in cycle N can be popped in cycle N+1.
// Ports    : clk, reset (sync, active-high)
//            i_push / i_pushData : write strobe and word
//            i_pop               : remove head word (ignored when empty)
//            o_popData           : head word
//            o_count             : words held (0..DEPTH)
//            o_full / o_empty    : status flags
// Revision : 1.0  initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_popData,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_popData = r_mem[r_rdPtr];

    // Full is evaluated before any same-cycle pop frees a slot
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    // Storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/draw_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : draw_cmd_receiver
// Purpose  : Receives 16-bit command words from the memory controller,
//            buffers them in a FIFO and parses NOP / PIXEL / HLINE / CLEAR
//            commands into a stream of pixel writes (valid/ready handshake).
// Ports    : clk, reset (sync, active-high)
//            we, dataIn   : command word write from the memory controller
//            full         : FIFO holds DEPTH words (further writes dropped)
//            px_valid, px_ready, px_x, px_y, px_color : pixel write port
//            busy         : parser not idle or FIFO not empty
//            err_count    : only with DRAW_CMD_ERR_EN defined; saturating
//                           count of illegal headers and dropped writes
// Config   : `define DRAW_CMD_ERR_EN to add the err_count output
// Revision : 1.0  initial release
// ============================================================================
module draw_cmd_receiver
    import draw_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int XMAX  = 159,
    parameter int YMAX  = 119
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [15:0]        dataIn,
    output logic               full,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [XW-1:0]      px_x,
    output logic [YW-1:0]      px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               busy
`ifdef DRAW_CMD_ERR_EN
    ,
    output logic [7:0]         err_count
`endif
);

    localparam logic [XW-1:0] c_xMax = XW'(XMAX);
    localparam logic [YW-1:0] c_yMax = YW'(YMAX);

    logic [15:0]             w_fifoWord;
    logic [$clog2(DEPTH):0]  w_fifoCount;
    logic                    w_fifoEmpty;
    logic                    w_acceptState;
    logic                    w_pop;
    logic [3:0]              w_opcode;
    logic                    w_unused;

    parse_state_t            r_state;
    logic [3:0]              r_cmd;
    logic [XW:0]             r_remaining;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (we),
        .i_pushData (dataIn),
        .i_pop      (w_pop),
        .o_popData  (w_fifoWord),
        .o_count    (w_fifoCount),
        .o_full     (full),
        .o_empty    (w_fifoEmpty)
    );

    // Only the header and coordinate fields of a word are meaningful
    assign w_unused = ^{w_fifoWord, w_fifoCount};

    assign w_opcode      = w_fifoWord[15:12];
    assign w_acceptState = (r_state == ST_IDLE)  || (r_state == ST_GET_X) ||
                           (r_state == ST_GET_Y) || (r_state == ST_GET_LEN);
    assign w_pop         = w_acceptState & ~w_fifoEmpty;
    assign busy          = (r_state != ST_IDLE) | ~w_fifoEmpty;

    // px_valid is raised on the transition into EMIT so it is registered
    // together with the coordinates it qualifies.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= OP_NOP;
            r_remaining <= '0;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_color    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cmd <= w_opcode;
                        case (w_opcode)
                            OP_PIXEL, OP_HLINE: begin
                                px_color <= w_fifoWord[COLOR_W-1:0];
                                r_state  <= ST_GET_X;
                            end
                            OP_CLEAR: begin
                                px_color <= w_fifoWord[COLOR_W-1:0];
                                px_x     <= '0;
                                px_y     <= '0;
                                px_valid <= 1'b1;
                                r_state  <= ST_EMIT;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end

                ST_GET_X: begin
                    if (w_pop) begin
                        px_x    <= w_fifoWord[XW-1:0];
                        r_state <= ST_GET_Y;
                    end
                end

                ST_GET_Y: begin
                    if (w_pop) begin
                        px_y <= w_fifoWord[YW-1:0];
                        if (r_cmd == OP_PIXEL) begin
                            r_remaining <= (XW+1)'(1);
                            px_valid    <= 1'b1;
                            r_state     <= ST_EMIT;
                        end else begin
                            r_state <= ST_GET_LEN;
                        end
                    end
                end

                ST_GET_LEN: begin
                    if (w_pop) begin
                        if (w_fifoWord[XW:0] == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_remaining <= w_fifoWord[XW:0];
                            px_valid    <= 1'b1;
                            r_state     <= ST_EMIT;
                        end
                    end
                end

                ST_EMIT: begin
                    if (px_valid && px_ready) begin
                        if (r_cmd == OP_CLEAR) begin
                            // Raster scan of the whole frame, row by row
                            if (px_x == c_xMax) begin
                                if (px_y == c_yMax) begin
                                    px_valid <= 1'b0;
                                    r_state  <= ST_IDLE;
                                end else begin
                                    px_x <= '0;
                                    px_y <= px_y + 1'b1;
                                end
                            end else begin
                                px_x <= px_x + 1'b1;
                            end
                        end else begin
                            // PIXEL is an HLINE of length one; x wraps freely
                            if (r_remaining == (XW+1)'(1)) begin
                                px_valid <= 1'b0;
                                r_state  <= ST_IDLE;
                            end else begin
                                px_x        <= px_x + 1'b1;
                                r_remaining <= r_remaining - 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    px_valid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DRAW_CMD_ERR_EN
    logic       w_illegal;
    logic       w_drop;
    logic [8:0] w_errSum;

    assign w_illegal = (r_state == ST_IDLE) && w_pop && (w_opcode > OP_CLEAR);
    assign w_drop    = we & full;
    assign w_errSum  = {1'b0, err_count} + {8'd0, w_illegal} + {8'd0, w_drop};

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (w_errSum > 9'd255) begin
            err_count <= 8'hFF;
        end else begin
            err_count <= w_errSum[7:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_draw_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_cmd_receiver
// Purpose  : Self-checking bench for draw_cmd_receiver. Expected pixels are
//            queued when a command is written and compared in order as the
//            DUT hands them off. Define DRAW_CMD_ERR_EN to include err_count.
// Revision : 1.0  initial release
// ============================================================================
module tb_draw_cmd_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [15:0] dataIn = '0;
    logic        full;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic [7:0]  px_x;
    logic [6:0]  px_y;
    logic [2:0]  px_color;
    logic        busy;
`ifdef DRAW_CMD_ERR_EN
    logic [7:0]  err_count;
`endif

    draw_cmd_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .dataIn    (dataIn),
        .full      (full),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .busy      (busy)
`ifdef DRAW_CMD_ERR_EN
        ,
        .err_count (err_count)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    typedef struct {
        logic [3:0][15:0] w;
        int               n;
        int               expN;
        logic [7:0]       x0;
        logic [6:0]       y;
        logic [2:0]       c;
        int               illegal;
    } vec_t;

    px_t  pxq[$];
    vec_t vt[8];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int hsCount = 0;
    int firstHs = -1;
    int lastHs = -1;
    int expErr = 0;
    bit prevStall = 0;
    px_t held;
    px_t lastPx;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Observe the pixel port at the falling edge: handshakes against the
    // scoreboard, and output stability while stalled.
    task automatic sample();
        px_t e;
        cycle++;
        if (reset) begin
            prevStall = 0;
            return;
        end
        if (prevStall && px_valid) begin
            chk("stall_stable", {px_x, px_y, px_color}, {held.x, held.y, held.c});
        end
        if (px_valid && px_ready) begin
            hsCount++;
            if (firstHs < 0) firstHs = cycle;
            lastHs   = cycle;
            lastPx.x = px_x;
            lastPx.y = px_y;
            lastPx.c = px_color;
            if (pxq.size() == 0) begin
                chk("unexpected_px", {px_x, px_y, px_color}, 32'hFFFF_FFFF);
            end else begin
                e = pxq.pop_front();
                chk("px_xyc", {px_x, px_y, px_color}, {e.x, e.y, e.c});
            end
        end
        prevStall = px_valid && !px_ready;
        held.x = px_x;
        held.y = px_y;
        held.c = px_color;
    endtask

    // One clock: sample at negedge, then return 1 time unit after posedge
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [15:0] w);
        we     = 1'b1;
        dataIn = w;
        tick();
        we     = 1'b0;
    endtask

    task automatic pushPx(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        px_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        pxq.push_back(p);
    endtask

    task automatic drain(input bit toggle, input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (toggle) px_ready = ~px_ready;
            tick();
            if (!busy && pxq.size() == 0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: busy=%0b pending=%0d required busy=0 pending=0",
                     busy, pxq.size());
        end
        px_ready = 1'b1;
    endtask

    task automatic waitValid(input string name);
        for (int k = 0; k < 30 && !px_valid; k++) tick();
        chk(name, {31'd0, px_valid}, 32'd1);
    endtask

    task automatic checkErr(input string name);
`ifdef DRAW_CMD_ERR_EN
        chk(name, {24'd0, err_count}, expErr);
`endif
    endtask

    function automatic vec_t mkv(input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [15:0] w3,
                                 input int n, input int expN, input logic [7:0] x0,
                                 input logic [6:0] y, input logic [2:0] c, input int ill);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.n = n; v.expN = expN; v.x0 = x0; v.y = y; v.c = c; v.illegal = ill;
        return v;
    endfunction

    initial begin
        vt[0] = mkv(16'h1005, 16'h000A, 16'h0014, 16'h0000, 3, 1, 8'd10,  7'd20,  3'd5, 0);
        vt[1] = mkv(16'h2003, 16'h00FE, 16'h0003, 16'h0004, 4, 4, 8'd254, 7'd3,   3'd3, 0);
        vt[2] = mkv(16'h1FF6, 16'hFF05, 16'hFFFF, 16'h0000, 3, 1, 8'd5,   7'd127, 3'd6, 0);
        vt[3] = mkv(16'h2001, 16'h0010, 16'h0005, 16'hFE00, 4, 0, 8'd0,   7'd0,   3'd0, 0);
        vt[4] = mkv(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'd0,   7'd0,   3'd0, 0);
        vt[5] = mkv(16'h5000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'd0,   7'd0,   3'd0, 1);
        vt[6] = mkv(16'h1007, 16'h009F, 16'h0077, 16'h0000, 3, 1, 8'd159, 7'd119, 3'd7, 0);
        vt[7] = mkv(16'h2004, 16'h0050, 16'h0064, 16'h0001, 4, 1, 8'd80,  7'd100, 3'd4, 0);

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
        chk("rst_px_xyc",   {px_x, px_y, px_color}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        checkErr("rst_err_count");
        reset    = 1'b0;
        px_ready = 1'b1;

        // Table-driven commands with px_ready held high
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vt[i].expN; j++) pushPx(vt[i].x0 + 8'(j), vt[i].y, vt[i].c);
            firstHs = -1;
            hsCount = 0;
            for (int j = 0; j < vt[i].n; j++) writeWord(vt[i].w[j]);
            expErr += vt[i].illegal;
            drain(0, 200);
            chk("vec_hs_count", hsCount, vt[i].expN);
            if (vt[i].expN > 0) chk("vec_consecutive", lastHs - firstHs, vt[i].expN - 1);
        end
        checkErr("tbl_err_count");

        // PIXEL held off by px_ready=0 for 5 cycles
        px_ready = 1'b0;
        pushPx(8'd7, 7'd9, 3'd2);
        writeWord(16'h1002);
        writeWord(16'h0007);
        writeWord(16'h0009);
        waitValid("stall_wait_valid");
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid_held", {31'd0, px_valid}, 32'd1);
        end
        hsCount  = 0;
        px_ready = 1'b1;
        drain(0, 50);
        chk("stall_one_accept", hsCount, 1);

        // FIFO overflow while the parser is stalled in EMIT
        px_ready = 1'b0;
        pushPx(8'd1, 7'd2, 3'd1);
        writeWord(16'h1001);
        writeWord(16'h0001);
        writeWord(16'h0002);
        waitValid("full_wait_valid");
        for (int k = 0; k < 20; k++) begin
            if (k == 15) chk("full_at_15", {31'd0, full}, 32'd0);
            if (k == 16) chk("full_at_16", {31'd0, full}, 32'd1);
            writeWord(16'h0000);
        end
        chk("full_after_20", {31'd0, full}, 32'd1);
        expErr += 4;
        checkErr("full_err_count");
        px_ready = 1'b1;
        drain(0, 100);
        chk("full_cleared", {31'd0, full}, 32'd0);

        // Reset while HLINE is presenting its second pixel
        px_ready = 1'b0;
        writeWord(16'h2002);
        writeWord(16'h0010);
        writeWord(16'h0008);
        writeWord(16'h0004);
        writeWord(16'h1001);
        writeWord(16'h0001);
        waitValid("rst_mid_wait_valid");
        chk("rst_mid_first_x", px_x, 32'd16);
        pushPx(8'd16, 7'd8, 3'd2);
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
        chk("rst_mid_2nd_valid", {31'd0, px_valid}, 32'd1);
        chk("rst_mid_2nd_x", px_x, 32'd17);
        reset = 1'b1;
        tick();
        chk("rst_mid_valid_drop", {31'd0, px_valid}, 32'd0);
        chk("rst_mid_busy",       {31'd0, busy},     32'd0);
        reset  = 1'b0;
        expErr = 0;
        checkErr("rst_mid_err_count");
        pushPx(8'd33, 7'd49, 3'd3);
        hsCount = 0;
        writeWord(16'h1003);
        writeWord(16'h0021);
        writeWord(16'h0031);
        px_ready = 1'b1;
        drain(0, 50);
        chk("post_rst_hs", hsCount, 1);

        // CLEAR with px_ready toggling, followed by an illegal header
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++) pushPx(8'(x), 7'(y), 3'd1);
        hsCount = 0;
        writeWord(16'h3001);
        writeWord(16'h7000);
        expErr += 1;
        drain(1, 45000);
        chk("clear_hs_count", hsCount, 19200);
        chk("clear_last_xy", {lastPx.x, lastPx.y}, {8'd159, 7'd119});
        checkErr("clear_err_count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
